// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// Module   : ifu
// Brief    : Instruction fetch stage. Keeps the fetch PC and issues one
//            instruction-memory read at a time. It buffers the returned
//            instruction in a single entry and offers it to decode over
//            valid/ready. BRU redirects squash wrong-path work: in-flight
//            responses are dropped and an already-buffered entry is flagged
//            as a nop.
// Revision : 1.0 - initial release
// ============================================================================
module ifu #(
    parameter int                   CPU_WIDTH = 64,
    parameter int                   INS_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(64'h8000_0000)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_imem_valid,
    input  logic                 i_imem_ready,
    output logic [CPU_WIDTH-1:0] o_imem_addr,
    input  logic                 i_imem_rvalid,
    input  logic [INS_WIDTH-1:0] i_imem_rdata,
    input  logic                 i_bru_jump,
    input  logic [CPU_WIDTH-1:0] i_bru_pc,
    output logic                 o_post_valid,
    input  logic                 i_post_ready,
    output logic [INS_WIDTH-1:0] o_ifu_ins,
    output logic [CPU_WIDTH-1:0] o_ifu_pc,
    output logic                 o_ifu_nop
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_HOLD = 2'd3;

    logic [1:0]           r_state;
    logic [CPU_WIDTH-1:0] r_pc;
    logic                 r_drop;
    logic [CPU_WIDTH-1:0] r_fetch_addr;
    logic [INS_WIDTH-1:0] r_ins;
    logic [CPU_WIDTH-1:0] r_pc_out;
    logic                 r_nop;
    logic                 r_post_valid;

    logic [1:0]           w_state_next;
    logic [CPU_WIDTH-1:0] w_pc_next;
    logic                 w_drop_next;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_handshake;
    logic                 w_set_nop;
    logic                 w_imem_valid;
    logic [CPU_WIDTH-1:0] w_redirect_pc;

    // Redirect targets are word aligned; the low target bits carry no meaning.
    assign w_redirect_pc = {i_bru_pc[CPU_WIDTH-1:2], 2'b00};

    logic [1:0] w_unused_bits;
    assign w_unused_bits = i_bru_pc[1:0];

    // Next-state, fetch-PC and drop-flag decisions for the fetch FSM.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_drop_next  = r_drop;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_handshake  = 1'b0;
        w_set_nop    = 1'b0;
        w_imem_valid = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_state_next = c_REQ;
            end
            c_REQ: begin
                w_imem_valid = 1'b1;
                if (i_imem_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = c_WAIT;
                    w_pc_next    = r_pc + CPU_WIDTH'(4);
                    // The accepted request is now wrong-path; drop its reply.
                    if (i_bru_jump) begin
                        w_drop_next = 1'b1;
                    end
                end
            end
            c_WAIT: begin
                if (i_imem_rvalid) begin
                    w_state_next = c_REQ;
                    w_drop_next  = 1'b0;
                    if (!r_drop && !i_bru_jump) begin
                        w_load       = 1'b1;
                        w_state_next = c_HOLD;
                    end
                end else if (i_bru_jump) begin
                    w_drop_next = 1'b1;
                end
            end
            c_HOLD: begin
                w_set_nop = i_bru_jump;
                if (r_post_valid && i_post_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = c_REQ;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
        // A redirect wins over the sequential +4 in the same cycle.
        if (i_bru_jump && (r_state != c_IDLE)) begin
            w_pc_next = w_redirect_pc;
        end
    end

    // FSM state, fetch PC and drop flag registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_IDLE;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_drop  <= w_drop_next;
        end
    end

    // Address of the in-flight request and the one-entry output buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_addr <= '0;
            r_ins        <= '0;
            r_pc_out     <= '0;
            r_nop        <= 1'b0;
            r_post_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fetch_addr <= r_pc;
            end
            if (w_load) begin
                r_ins        <= i_imem_rdata;
                r_pc_out     <= r_fetch_addr;
                r_nop        <= 1'b0;
                r_post_valid <= 1'b1;
            end else if (w_handshake) begin
                r_post_valid <= 1'b0;
                r_nop        <= 1'b0;
            end else if (w_set_nop) begin
                r_nop <= 1'b1;
            end
        end
    end

    assign o_imem_valid = w_imem_valid;
    assign o_imem_addr  = r_pc;
    assign o_post_valid = r_post_valid;
    assign o_ifu_ins    = r_ins;
    assign o_ifu_pc     = r_pc_out;
    // Combinational squash so an entry taken in the redirect cycle is a nop.
    assign o_ifu_nop    = r_nop | (i_bru_jump & r_post_valid);

endmodule
`default_nettype wire

// File: doc/ifu.md
# ifu

Instruction fetch stage, the producer side of the IFU→IDU valid/ready boundary. Holds the architectural fetch PC and issues one instruction-memory read at a time. Captures the returned instruction into a one-entry output buffer and offers it to the decode stage with `o_post_valid` / `i_post_ready`. Applies branch/jump redirects from the BRU, squashing wrong-path fetches by dropping in-flight responses and flagging already-buffered entries as nop.

## Interface

Parameters:
- `CPU_WIDTH`, 64, PC / address width
- `INS_WIDTH`, 32, instruction width
- `RESET_PC`, 64'h8000_0000, first fetch address after reset

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge
- `i_rst`  in  1  reset; synchronous, active-high
- `o_imem_valid`  out  1  fetch request valid
- `i_imem_ready`  in  1  request accepted this cycle when high together with `o_imem_valid`
- `o_imem_addr`  out  CPU_WIDTH  fetch address, bits [1:0] always 0
- `i_imem_rvalid`  in  1  read data valid
- `i_imem_rdata`  in  INS_WIDTH  read data
- `i_bru_jump`  in  1  redirect pulse, one cycle
- `i_bru_pc`  in  CPU_WIDTH  redirect target
- `o_post_valid`  out  1  buffered instruction valid to IDU
- `i_post_ready`  in  1  IDU can accept
- `o_ifu_ins`  out  INS_WIDTH  buffered instruction
- `o_ifu_pc`  out  CPU_WIDTH  PC of buffered instruction
- `o_ifu_nop`  out  1  buffered entry is wrong-path; IDU substitutes nop

## Operation

- State registers: `pc_r`, FSM `state`, `drop_r`, output buffer {`ins_r`, `pc_out_r`, `nop_r`, `o_post_valid`}.
- FSM states and transitions:
  - IDLE: entered only by reset. Goes to REQ next cycle unconditionally.
  - REQ: drives `o_imem_valid=1`, `o_imem_addr=pc_r`. When `i_imem_ready` is high, goes to WAIT and loads `pc_r <= pc_r+4`.
  - WAIT: waits for `i_imem_rvalid`.
    - If `drop_r`=0: loads the buffer with `ins_r<=i_imem_rdata`, `pc_out_r<=` fetched address, `nop_r<=0`, `o_post_valid<=1`, and goes to HOLD.
    - If `drop_r`=1: discards the data, clears `drop_r` and goes to REQ.
  - HOLD: `o_post_valid=1`. On `o_post_valid & i_post_ready`, clears `o_post_valid` and goes to REQ.
- Fetched address is kept in a register captured on accept; `pc_r` already points to the next sequential PC.
- Redirect (`i_bru_jump=1`) in any state except IDLE loads `pc_r <= {i_bru_pc[CPU_WIDTH-1:2], 2'b00}`. This overrides the +4 update in the same cycle. Per state:
  - REQ, not accepted: the request continues next cycle with the new address. The internal imem bus permits an address change while unaccepted.
  - REQ, accepted same cycle: set `drop_r`. The old-address response is discarded.
  - WAIT, no rvalid: set `drop_r`.
  - WAIT, rvalid same cycle: the data is discarded, the buffer is not loaded, and the FSM goes to REQ.
  - HOLD: set `nop_r`. The entry is still handed to IDU, flagged nop.
- `o_ifu_nop = nop_r | (i_bru_jump & o_post_valid)`. This is combinational, so an entry handed over in the redirect cycle is already squashed.
- `i_imem_rvalid` outside WAIT is ignored.
- Address arithmetic is modulo 2^CPU_WIDTH; +4 wraps at the top of the space.

## Timing

- Reset (`i_rst` high at an edge): state=IDLE, `pc_r=RESET_PC`, `drop_r=0`.
  - Outputs after reset: `o_imem_valid=0`, `o_post_valid=0`, `o_ifu_ins=0`, `o_ifu_pc=0`, `nop_r=0`.
  - Reset mid-transaction abandons everything. Any later `i_imem_rvalid` is ignored until WAIT is re-entered.
- First request: `o_imem_valid=1` in the first cycle after the cycle in which reset is sampled low.
- Latency:
  - Request accepted at cycle t; rvalid at cycle t+k, with k≥1.
  - `o_post_valid=1` from cycle t+k+1.
  - Handshake at cycle h gives the next request at cycle h+1.
  - Best case is one instruction per 3 cycles.
- At most one request outstanding. The output buffer never overflows because a request is issued only when the buffer is empty.
- `o_ifu_ins`, `o_ifu_pc` and `nop_r` are stable while `o_post_valid=1` and not handshaked. Only `o_ifu_nop` may rise, via `i_bru_jump`.

## Test plan

- Reset release with imem always ready and rvalid 1 cycle after accept:
  - Addr 0x80000000 at cycle 1; `o_post_valid` at cycle 3 with pc 0x80000000.
  - Next requests at 0x80000004 and 0x80000008, spaced 3 cycles apart.
- Backpressure: hold `i_post_ready=0` for 5 cycles.
  - `o_post_valid`, ins and pc stay constant; no new `o_imem_valid`.
  - One request issues the cycle after ready rises.
- Redirect in WAIT to 0x80000100, followed by rvalid with 0xDEADBEEF.
  - The data is dropped and never presented.
  - The next request is at 0x80000100.
- Redirect to 0x80000202 while in HOLD with ins 0x00000013 and ready=0.
  - `o_ifu_nop=1` immediately and stays 1 until handshake.
  - The next fetch address is 0x80000200.
- Redirect in REQ with `i_imem_ready=0`, target 0x80000040.
  - `o_imem_addr` becomes 0x80000040 the next cycle.
  - No drop; the response is presented with pc 0x80000040.
- Assert `i_rst` during WAIT, then deliver a stale rvalid in IDLE/REQ.
  - The stale data is ignored.
  - Fetch restarts at RESET_PC with `o_post_valid=0`.
